// File: rtl/seg_pkg.sv
// Shared constants, state encoding and helpers for the multiplexed seven-segment display.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    CV_IDLE = 1'b0,
    CV_RUN  = 1'b1
  } conv_state_e;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Ceiling log2, never below 1 so it can size a register directly.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Value/strobe/status/pin bundle between the game data holder and the display driver.
interface seg_scan_display_if #(
  parameter int W0    = 9,
  parameter int W1    = 14,
  parameter int N_DIG = 8
);
  logic [W0-1:0]    val0;
  logic [W1-1:0]    val1;
  logic             load;
  logic             busy;
  logic             ovf0;
  logic             ovf1;
  logic [6:0]       seg;
  logic [N_DIG-1:0] an;

  modport master (output val0, val1, load, input busy, ovf0, ovf1, seg, an);
  modport slave  (input val0, val1, load, output busy, ovf0, ovf1, seg, an);
endinterface

// File: rtl/bcd_serial_conv.sv
// Serial shift-add-3 binary to BCD converter, one bit per clock, MSB first, sticky overflow.
module bcd_serial_conv
  import seg_pkg::*;
#(
  parameter int W = 9,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf
);
  localparam int CW = clog2(W + 1);

  conv_state_e     state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [4*D-1:0]  bcd_q, bcd_d, adj_s;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CV_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Add-3 correction of every digit that is 5 or more before the shift.
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Next-state logic; done flags the final iteration in the cycle it is computed.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      CV_IDLE: begin
        if (start) begin
          state_d = CV_RUN;
          sh_d    = bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(W);
        end else begin
          state_d = CV_IDLE;
        end
      end
      CV_RUN: begin
        bcd_d = {adj_s[4*D-2:0], sh_q[W-1]};
        ovf_d = ovf_q | adj_s[4*D-1];
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = CV_IDLE;
          done    = 1'b1;
        end else begin
          state_d = CV_RUN;
        end
      end
      default: state_d = CV_IDLE;
    endcase
  end

  // Next-state view: final result during the done cycle, held result once idle.
  assign busy = (state_q == CV_RUN);
  assign bcd  = bcd_d;
  assign ovf  = ovf_d;

endmodule

// File: rtl/seg_scan_display.sv
// Two-field multiplexed seven-segment driver: atomic capture/convert, blanking, overflow dashes, scan.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int W0          = 9,
  parameter int D0          = 3,
  parameter int W1          = 14,
  parameter int D1          = 4,
  parameter int GAP         = 1,
  parameter int REFRESH_DIV = 17,
  parameter int BLANK_LZ    = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_display_if.slave bus
);
  localparam int N_DIG = D0 + GAP + D1;
  localparam int IW    = clog2(N_DIG);

  logic                     start_s, all_done_s;
  logic                     eb0_s, dn0_s, ov0_s, eb1_s, dn1_s, ov1_s;
  logic [4*D0-1:0]          bcd0_s;
  logic [4*D1-1:0]          bcd1_s;
  logic [D0-1:0][6:0]       fld0_s;
  logic [D1-1:0][6:0]       fld1_s;
  logic                     nz0_s, nz1_s;
  logic                     busy_q, busy_d, ovf0_q, ovf0_d, ovf1_q, ovf1_d;
  logic [N_DIG-1:0][6:0]    disp_q, disp_d;
  logic [REFRESH_DIV-1:0]   presc_q;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_DIG-1:0]         an_q, an_d;
  logic [6:0]               seg_q, seg_d;

  assign start_s    = bus.load & ~busy_q;
  assign all_done_s = busy_q & (dn0_s | ~eb0_s) & (dn1_s | ~eb1_s);

  bcd_serial_conv #(.W(W0), .D(D0)) u_conv0 (
    .clk(clk), .rst(rst), .start(start_s), .bin(bus.val0),
    .busy(eb0_s), .done(dn0_s), .bcd(bcd0_s), .ovf(ov0_s)
  );

  bcd_serial_conv #(.W(W1), .D(D1)) u_conv1 (
    .clk(clk), .rst(rst), .start(start_s), .bin(bus.val1),
    .busy(eb1_s), .done(dn1_s), .bcd(bcd1_s), .ovf(ov1_s)
  );

  // Low field codes, walking down from the top digit to find the first non-zero one.
  always_comb begin
    fld0_s = '0;
    nz0_s  = 1'b0;
    for (int i = D0 - 1; i >= 0; i--) begin
      if (ov0_s) begin
        fld0_s[i] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && !nz0_s && (i != 0) && (bcd0_s[4*i +: 4] == 4'd0)) begin
        fld0_s[i] = SEG_BLANK;
      end else begin
        fld0_s[i] = seg_digit(bcd0_s[4*i +: 4]);
      end
      nz0_s = nz0_s | (bcd0_s[4*i +: 4] != 4'd0);
    end
  end

  // High field codes, same rules as the low field.
  always_comb begin
    fld1_s = '0;
    nz1_s  = 1'b0;
    for (int i = D1 - 1; i >= 0; i--) begin
      if (ov1_s) begin
        fld1_s[i] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && !nz1_s && (i != 0) && (bcd1_s[4*i +: 4] == 4'd0)) begin
        fld1_s[i] = SEG_BLANK;
      end else begin
        fld1_s[i] = seg_digit(bcd1_s[4*i +: 4]);
      end
      nz1_s = nz1_s | (bcd1_s[4*i +: 4] != 4'd0);
    end
  end

  // Capture/busy control and the atomic display/overflow update; gap digits keep their reset blank.
  always_comb begin
    disp_d = disp_q;
    ovf0_d = ovf0_q;
    ovf1_d = ovf1_q;
    if (start_s) begin
      busy_d = 1'b1;
    end else if (all_done_s) begin
      busy_d = 1'b0;
      ovf0_d = ov0_s;
      ovf1_d = ov1_s;
      for (int i = 0; i < D0; i++) begin
        disp_d[i] = fld0_s[i];
      end
      for (int i = 0; i < D1; i++) begin
        disp_d[N_DIG - D1 + i] = fld1_s[i];
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // Digit index advance on prescaler terminal count, plus the next pin values.
  always_comb begin
    if (&presc_q) begin
      if (idx_q == IW'(N_DIG - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    an_d  = ~(N_DIG'(1) << idx_d);
    seg_d = disp_q[idx_d];
  end

  // All registers of the control path, display store and scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      disp_q  <= {N_DIG{SEG_BLANK}};
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~(N_DIG'(1));
      seg_q   <= SEG_BLANK;
    end else begin
      busy_q  <= busy_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
      disp_q  <= disp_d;
      presc_q <= presc_q + REFRESH_DIV'(1);
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf0 = ovf0_q;
  assign bus.ovf1 = ovf1_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised bench for seg_scan_display against a decimal-arithmetic display model (BLANK_LZ 1 and 0).
module tb_seg_scan_display;
  localparam int W0 = 9;
  localparam int D0 = 3;
  localparam int W1 = 14;
  localparam int D1 = 4;
  localparam int GAP = 1;
  localparam int ND = D0 + GAP + D1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W0-1:0] v0_t;
  logic [W1-1:0] v1_t;
  logic          load_t;
  int            n_total = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_display_if #(.W0(W0), .W1(W1), .N_DIG(ND)) bus_a ();
  seg_scan_display_if #(.W0(W0), .W1(W1), .N_DIG(ND)) bus_b ();

  assign bus_a.val0 = v0_t;
  assign bus_a.val1 = v1_t;
  assign bus_a.load = load_t;
  assign bus_b.val0 = v0_t;
  assign bus_b.val1 = v1_t;
  assign bus_b.load = load_t;

  seg_scan_display #(.W0(W0), .D0(D0), .W1(W1), .D1(D1), .GAP(GAP), .REFRESH_DIV(2), .BLANK_LZ(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seg_scan_display #(.W0(W0), .D0(D0), .W1(W1), .D1(D1), .GAP(GAP), .REFRESH_DIV(2), .BLANK_LZ(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  bit m_valid;
  int m_v0;
  int m_v1;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_field(input int v, input int nd, input int i, input bit blz);
    if (v >= pow10(nd)) return 7'h3F;
    if (blz && (i > 0) && (v < pow10(i))) return 7'h7F;
    return seg_tab[(v / pow10(i)) % 10];
  endfunction

  function automatic logic [6:0] exp_digit(input int d, input bit blz);
    if (!m_valid) return 7'h7F;
    if (d < D0) return exp_field(m_v0, D0, d, blz);
    if (d < D0 + GAP) return 7'h7F;
    return exp_field(m_v1, D1, d - D0 - GAP, blz);
  endfunction

  // Watch a full scan frame on both DUTs and compare every digit with the model.
  task automatic check_frame(input string tag);
    logic [6:0] cap_a [ND];
    logic [6:0] cap_b [ND];
    bit         seen_a [ND];
    bit         seen_b [ND];
    logic [ND-1:0] oh;
    for (int d = 0; d < ND; d++) begin
      cap_a[d] = 7'h00; cap_b[d] = 7'h00; seen_a[d] = 1'b0; seen_b[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < ND * 4 + 4; c++) begin
      for (int d = 0; d < ND; d++) begin
        oh = ~(ND'(1) << d);
        if (bus_a.an == oh) begin seen_a[d] = 1'b1; cap_a[d] = bus_a.seg; end
        if (bus_b.an == oh) begin seen_b[d] = 1'b1; cap_b[d] = bus_b.seg; end
      end
      @(negedge clk);
    end
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("%s_seen_a%0d", tag, d), 32'(seen_a[d]), 32'd1);
      check_val($sformatf("%s_seen_b%0d", tag, d), 32'(seen_b[d]), 32'd1);
      check_val($sformatf("%s_lz1_dig%0d", tag, d), 32'(cap_a[d]), 32'(exp_digit(d, 1'b1)));
      check_val($sformatf("%s_lz0_dig%0d", tag, d), 32'(cap_b[d]), 32'(exp_digit(d, 1'b0)));
    end
  endtask

  // Load a pair of values, optionally try a second load re_at cycles in, then check busy, ovf and display.
  task automatic do_conv(input int a0, input int a1, input int re_at, input int r0, input int r1);
    int cnt;
    @(negedge clk);
    v0_t = W0'(a0);
    v1_t = W1'(a1);
    load_t = 1'b1;
    @(negedge clk);
    load_t = 1'b0;
    cnt = 0;
    while ((bus_a.busy === 1'b1) && (cnt < 100)) begin
      cnt++;
      if (cnt == re_at) begin
        v0_t = W0'(r0);
        v1_t = W1'(r1);
        load_t = 1'b1;
      end else begin
        load_t = 1'b0;
      end
      @(negedge clk);
    end
    load_t = 1'b0;
    check_val("busy_len", 32'(cnt), 32'd14);
    m_valid = 1'b1;
    m_v0 = a0;
    m_v1 = a1;
    check_val("ovf0_a", 32'(bus_a.ovf0), 32'(a0 >= 1000));
    check_val("ovf1_a", 32'(bus_a.ovf1), 32'(a1 >= 10000));
    check_val("ovf1_b", 32'(bus_b.ovf1), 32'(a1 >= 10000));
    check_frame($sformatf("frm_%0d_%0d", a0, a1));
  endtask

  initial begin
    logic [ND-1:0] exp_an;
    int r0;
    int r1;
    rst = 1'b1;
    load_t = 1'b0;
    v0_t = '0;
    v1_t = '0;
    m_valid = 1'b0;
    m_v0 = 0;
    m_v1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_an", 32'(bus_a.an), 32'hFE);
    check_val("rst_seg", 32'(bus_a.seg), 32'h7F);
    check_val("rst_busy", 32'(bus_a.busy), 32'd0);
    check_val("rst_ovf0", 32'(bus_a.ovf0), 32'd0);
    check_val("rst_ovf1", 32'(bus_a.ovf1), 32'd0);
    rst = 1'b0;

    for (int k = 0; k <= 36; k++) begin
      exp_an = ~(ND'(1) << ((k / 4) % ND));
      check_val("scan_an", 32'(bus_a.an), 32'(exp_an));
      @(negedge clk);
    end

    check_frame("blank_idle");
    do_conv(59, 1234, 0, 0, 0);
    do_conv(0, 0, 0, 0, 0);
    do_conv(511, 12000, 0, 0, 0);
    do_conv(7, 9999, 0, 0, 0);
    do_conv(305, 4020, 5, 1, 8888);

    for (int n = 0; n < 8; n++) begin
      r0 = int'($urandom_range(0, (n % 3 == 0) ? 9 : 511));
      r1 = int'($urandom_range(0, (n % 3 == 0) ? 99 : 16383));
      do_conv(r0, r1, 0, 0, 0);
    end

    do_conv(40, 15000, 0, 0, 0);
    @(negedge clk);
    v0_t = W0'(123);
    v1_t = W1'(4567);
    load_t = 1'b1;
    @(negedge clk);
    load_t = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    check_val("mid_rst_an", 32'(bus_a.an), 32'hFE);
    check_val("mid_rst_seg", 32'(bus_a.seg), 32'h7F);
    check_val("mid_rst_ovf1", 32'(bus_a.ovf1), 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_frame("after_rst");
    do_conv(88, 321, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised successor to the two-field seven-segment interface. It displays two unsigned binary values (e.g. score and game time) on an N-digit multiplexed display. Values are captured on a load strobe and converted by sequential double-dabble engines, so display digits update atomically and never tear. Adds leading-zero blanking, per-field overflow indication, a configurable blank gap and a configurable refresh rate. Sits between the game data holder and the board's segment/anode pins.

## Interface
- `W0`, default 9: width of low field value.
- `D0`, default 3: BCD digits of low field, occupying display digits 0..D0-1.
- `W1`, default 14: width of high field value.
- `D1`, default 4: BCD digits of high field, occupying the top D1 display digits.
- `GAP`, default 1: blank digits between the fields.
- `REFRESH_DIV`, default 17: each digit is lit for 2^REFRESH_DIV clocks.
- `BLANK_LZ`, default 1: enables leading-zero suppression.
- Derived (not overridable): `N_DIG` = D0+GAP+D1.

Ports:
- `clk`  in  1  board clock.
- `rst`  in  1  asynchronous, active-high reset.
- `val0`  in  W0  low field value, sampled on load.
- `val1`  in  W1  high field value, sampled on load.
- `load`  in  1  one-cycle capture request.
- `busy`  out  1  conversion in progress.
- `ovf0`, `ovf1`  out  1 each  field value ≥ 10^D.
- `seg`  out  7  segments, seg[0]=a … seg[6]=g, active low.
- `an`  out  N_DIG  digit anodes, one-hot active low.

## Operation
- Idle with `load`=1: capture `val0`/`val1`; both engines start together.
- `load` while busy is ignored; no queuing.
- Engine: shift-add-3, one bit per clock, MSB first, W iterations. A 1 shifted out of the top BCD digit at any step sets a sticky overflow for that conversion.
- Done when both engines finish. In that same cycle, all display digit registers, `ovf0` and `ovf1` update together, and `busy` falls.
- Digit code per field:
  - Overflowed field: every digit shows a dash (g only, 7'b0111111).
  - Otherwise, with BLANK_LZ=1: zero digits above the most significant non-zero digit are blanked; the field's lowest digit is always shown.
- Gap digits are always blank (7'h7F).
- Scan:
  - Prescaler counts 0..2^REFRESH_DIV-1; terminal count advances the digit index.
  - Index runs 0..N_DIG-1 and wraps to 0.
  - `an` = ~(1<<index).
  - `seg` = pattern of the indexed digit.
- Reset (any time, including mid-conversion):
  - Conversion aborted, `busy`=0.
  - Display registers hold blank codes, `ovf0`=`ovf1`=0.
  - Index 0, prescaler 0.

## Timing
- Reset values: `an`={N_DIG{1}} with bit 0 = 0; `seg`=7'h7F; `busy`=0; `ovf0`=`ovf1`=0.
- `busy` is high from the clock after `load` for exactly max(W0,W1) cycles.
- Display registers and ovf flags change on the edge where `busy` falls.
- `seg`/`an` are registered and change on the same edge.
- A new value shows on `seg` one clock after the display update if its digit is selected, otherwise at that digit's next scan slot.
- Digit slot = 2^REFRESH_DIV clocks; full frame = N_DIG slots.

## Structure
- Shared package `seg_pkg`:
  - segment constants SEG_BLANK, SEG_DASH;
  - 0–9 pattern function;
  - clog2 function for index width.
- Sub-module `bcd_serial_conv` (params W, D; ports clk, rst, start, bin, busy, done, bcd[4D-1:0], ovf), instantiated once per field.
- Top level holds the capture logic, display registers, blanking logic, prescaler and scan.

## Test plan
All scenarios use REFRESH_DIV=2.
1. Reset -> `an`=8'hFE, `seg`=7'h7F, `busy`=0; after release `an` steps FE,FD,FB,…,7F,FE, one step every 4 clocks.
2. load val1=1234, val0=59 -> `busy` high 14 cycles; digits 7..4 show 1,2,3,4; digit 3 blank; digit 2 blank (leading zero); digits 1,0 show 5,9.
3. load val1=0, val0=0 -> digits 7..5 blank, digit 4 '0'; digits 2,1 blank, digit 0 '0'; with BLANK_LZ=0, all field digits show '0'.
4. load val1=12000 -> digits 7..4 show dashes, `ovf1`=1; next load val1=9999 -> 9,9,9,9 and `ovf1`=0.
5. Second `load` with new values 5 cycles into a conversion -> ignored; display shows the first values.
6. `rst` asserted mid-conversion -> `busy`=0 immediately, all digits blank; a following load converts correctly.
